// File: rtl/demux_lane_deserializer_pkg.sv
// Shared constants and helpers for the demux lane deserializer.
package demux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  // Bit offset of lane n's word inside the packed word_out bus.
  function automatic int unsigned lane_slice(input int unsigned n, input int unsigned width);
    return n * width;
  endfunction

endpackage

// File: rtl/demux_lane_deserializer_if.sv
// Bit-serial demux input side and per-lane parallel word output side.
interface demux_lane_deserializer_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic                       bit_valid;
  logic [SEL_W-1:0]           sel;
  logic                       data_out_0;
  logic                       data_out_1;
  logic                       data_out_2;
  logic                       data_out_3;
  logic [NUM_LANES*WIDTH-1:0] word_out;
  logic [NUM_LANES-1:0]       word_valid;
  logic [NUM_LANES-1:0]       word_ready;
  logic [NUM_LANES-1:0]       overflow;
  logic                       clear_ovf;

  // Drives the serial bits and consumes words.
  modport master (
    output bit_valid, sel, data_out_0, data_out_1, data_out_2, data_out_3, word_ready, clear_ovf,
    input  word_out, word_valid, overflow
  );

  // The deserializer itself.
  modport slave (
    input  bit_valid, sel, data_out_0, data_out_1, data_out_2, data_out_3, word_ready, clear_ovf,
    output word_out, word_valid, overflow
  );

endinterface

// File: rtl/demux_lane_deserializer_lane_deser.sv
// One lane: MSB-first shift register, bit counter, holding register with
// valid/ready handshake and a sticky overflow flag for dropped words.
module lane_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic             ready,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  // Only WIDTH-1 bits need storing; the final bit goes straight into the word.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] new_word;
  logic             complete;

  assign new_word = {shreg_q, bit_in};
  assign complete = bit_en && (cnt_q == CntLast);

  // Next-state: shift, count, load/drop completed words, handshake, overflow.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovf_d   = clear_ovf ? 1'b0 : ovf_q;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    if (bit_en) begin
      shreg_d = new_word[WIDTH-2:0];
      cnt_d   = complete ? '0 : cnt_q + 1'b1;
    end

    if (complete) begin
      if (!valid_q || ready) begin
        word_d  = new_word;
        valid_d = 1'b1;
      end else begin
        // Set wins over a coincident clear.
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word  = word_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/demux_lane_deserializer.sv
// Turns the time-multiplexed 1-to-4 demux output into four parallel word
// streams. The top level only decodes sel and picks the active data bit.
module demux_lane_deserializer
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  demux_lane_deserializer_if.slave  bus
);

  logic [NUM_LANES-1:0] data_bits;

  assign data_bits = {bus.data_out_3, bus.data_out_2, bus.data_out_1, bus.data_out_0};

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    localparam int unsigned Off = lane_slice(n, WIDTH);
    logic bit_en;

    assign bit_en = bus.bit_valid && (bus.sel == SEL_W'(n));

    lane_deser #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .bit_en   (bit_en),
      .bit_in   (data_bits[n]),
      .ready    (bus.word_ready[n]),
      .clear_ovf(bus.clear_ovf),
      .word     (bus.word_out[Off +: WIDTH]),
      .valid    (bus.word_valid[n]),
      .ovf      (bus.overflow[n])
    );
  end

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// Directed bench for the demux lane deserializer, WIDTH=8.
module tb_demux_lane_deserializer;
  import demux_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  demux_lane_deserializer_if #(.WIDTH(W)) bus ();

  demux_lane_deserializer #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int lane, input logic b);
    logic [3:0] r;
    r = 4'($urandom);
    {bus.data_out_3, bus.data_out_2, bus.data_out_1, bus.data_out_0} = r;
    case (lane)
      0: bus.data_out_0 = b;
      1: bus.data_out_1 = b;
      2: bus.data_out_2 = b;
      default: bus.data_out_3 = b;
    endcase
  endtask

  task automatic send_bit(input int lane, input logic b);
    bus.bit_valid = 1'b1;
    bus.sel       = 2'(lane);
    set_data(lane, b);
    tick();
    bus.bit_valid = 1'b0;
  endtask

  task automatic gap();
    bus.bit_valid = 1'b0;
    bus.sel       = 2'($urandom);
    set_data(0, 1'($urandom));
    tick();
  endtask

  task automatic send_word(input int lane, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(lane, w[i]);
  endtask

  function automatic logic [7:0] lane_word(input int lane);
    return bus.word_out[lane*8 +: 8];
  endfunction

  task automatic drain(input logic [3:0] mask);
    bus.word_ready = mask;
    tick();
    bus.word_ready = 4'b0000;
  endtask

  initial begin
    logic [7:0] a6;
    logic [7:0] h22;
    a6  = 8'hA6;
    h22 = 8'h22;

    // Reset with garbage on every input.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.bit_valid  = 1'b1;
      bus.sel        = 2'($urandom);
      set_data(0, 1'($urandom));
      bus.word_ready = 4'($urandom);
      bus.clear_ovf  = 1'($urandom);
      tick();
    end
    check_eq("rst_valid", 32'(bus.word_valid), 32'h0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'h0);
    check_eq("rst_word", bus.word_out, 32'h0);
    rst            = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.word_ready = 4'b0000;
    bus.clear_ovf  = 1'b0;
    tick();

    // Single lane 2, bits 1,0,1,0,0,1,1,0 -> A6.
    for (int i = 7; i >= 0; i--) begin
      send_bit(2, a6[i]);
      if (i == 1) check_eq("single_no_early_valid", 32'(bus.word_valid), 32'h0);
    end
    check_eq("single_valid", 32'(bus.word_valid), 32'h4);
    check_eq("single_word", 32'(lane_word(2)), 32'hA6);
    tick();
    check_eq("single_hold", 32'(lane_word(2)), 32'hA6);
    drain(4'b0100);
    check_eq("single_accepted", 32'(bus.word_valid), 32'h0);

    // Interleaved lanes 0/1, first without gaps, then with gaps.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 16; i++) begin
        send_bit(i % 2, (i % 2) == 0);
        if (g == 1 && (i % 3) == 1) gap();
      end
      check_eq($sformatf("ilv%0d_valid", g), 32'(bus.word_valid), 32'h3);
      check_eq($sformatf("ilv%0d_lane0", g), 32'(lane_word(0)), 32'hFF);
      check_eq($sformatf("ilv%0d_lane1", g), 32'(lane_word(1)), 32'h00);
      check_eq($sformatf("ilv%0d_ovf", g), 32'(bus.overflow), 32'h0);
      drain(4'b0011);
      check_eq($sformatf("ilv%0d_drained", g), 32'(bus.word_valid), 32'h0);
    end

    // Overflow on lane 3: 5A held, 3C dropped.
    send_word(3, 8'h5A);
    check_eq("ovf_first_valid", 32'(bus.word_valid), 32'h8);
    send_word(3, 8'h3C);
    check_eq("ovf_flag", 32'(bus.overflow), 32'h8);
    check_eq("ovf_word_kept", 32'(lane_word(3)), 32'h5A);
    check_eq("ovf_valid_kept", 32'(bus.word_valid), 32'h8);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    check_eq("ovf_cleared", 32'(bus.overflow), 32'h0);

    // Clear coinciding with a new drop: set wins.
    for (int i = 0; i < 7; i++) send_bit(3, 1'b1);
    bus.clear_ovf = 1'b1;
    send_bit(3, 1'b1);
    bus.clear_ovf = 1'b0;
    check_eq("ovf_set_wins", 32'(bus.overflow), 32'h8);
    check_eq("ovf_set_wins_word", 32'(lane_word(3)), 32'h5A);
    bus.clear_ovf = 1'b1;
    tick();
    bus.clear_ovf = 1'b0;
    drain(4'b1000);
    check_eq("ovf_drained", 32'(bus.word_valid), 32'h0);

    // Lane 1 holds 11; final bit of 22 arrives together with ready.
    send_word(1, 8'h11);
    check_eq("reload_first", 32'(lane_word(1)), 32'h11);
    for (int i = 7; i >= 1; i--) send_bit(1, h22[i]);
    bus.word_ready = 4'b0010;
    send_bit(1, h22[0]);
    bus.word_ready = 4'b0000;
    check_eq("reload_valid", 32'(bus.word_valid), 32'h2);
    check_eq("reload_word", 32'(lane_word(1)), 32'h22);
    check_eq("reload_ovf", 32'(bus.overflow), 32'h0);
    drain(4'b0010);
    check_eq("reload_drained", 32'(bus.word_valid), 32'h0);

    // Ready with nothing valid has no effect.
    bus.word_ready = 4'b1111;
    tick();
    tick();
    bus.word_ready = 4'b0000;
    check_eq("idle_ready", 32'(bus.word_valid), 32'h0);

    // Reset mid-word discards the partial bits.
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_valid", 32'(bus.word_valid), 32'h0);
    send_word(0, 8'hC3);
    check_eq("midrst_word_valid", 32'(bus.word_valid), 32'h1);
    check_eq("midrst_word", 32'(lane_word(0)), 32'hC3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_lane_deserializer.md
Name: demux_lane_deserializer

Overview:
- Downstream consumer of the 1-to-4 demultiplexer.
- Each cycle it takes the demux select and the four demux output bits, and shifts the bit on the selected lane into that lane's shift register.
- After WIDTH bits on a lane, it presents a parallel word on that lane with a valid/ready handshake.
- It turns the bit-serial, time-multiplexed demux output into four independent parallel word streams.

Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.
- NUM_LANES, 4, number of demux lanes; fixed at 4 (SEL_W = 2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_valid  input  1  the demux outputs and sel are meaningful this cycle.
- sel  input  2  lane select driven to the demux; identifies the active lane.
- data_out_0  input  1  demux lane 0 output.
- data_out_1  input  1  demux lane 1 output.
- data_out_2  input  1  demux lane 2 output.
- data_out_3  input  1  demux lane 3 output.
- word_out  output  4*WIDTH  lane n's word at bits [n*WIDTH +: WIDTH].
- word_valid  output  4  per-lane holding register full.
- word_ready  input  4  per-lane consumer accepts the word.
- overflow  output  4  sticky per-lane word-dropped flag.
- clear_ovf  input  1  clears all overflow bits.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all shift registers, bit counters, word_out, word_valid and overflow go to 0.
  - Reset mid-word discards the partial bits.
  - rst has priority over every other input.
- Bit acceptance:
  - When bit_valid=1, lane L=sel accepts bit data_out_L.
  - The other three data_out inputs are ignored that cycle.
  - When bit_valid=0, no lane shifts.
- Shifting is MSB-first: shreg_L <= {shreg_L[WIDTH-2:0], bit}. The first bit received lands in word bit WIDTH-1.
- Per-lane bit counter runs 0..WIDTH-1:
  - increments on each accepted bit for that lane;
  - wraps to 0 on the WIDTH-th bit.
- Word completion occurs when a lane accepts a bit with its counter at WIDTH-1.
  - If the holding register is empty, or is full and word_ready_L=1 in the same cycle:
    - load the holding register with {shreg_L[WIDTH-2:0], bit};
    - word_valid_L=1 from the next cycle.
    - Latency is 1 cycle from the final bit to word_valid.
  - If the holding register is full and word_ready_L=0:
    - the new word is dropped; overflow_L <= 1;
    - the holding word is kept unchanged;
    - the counter still wraps to 0.
- Handshake:
  - A transfer occurs on any edge where word_valid_L & word_ready_L.
  - word_valid_L then clears, unless a completing word reloads it in that same cycle, in which case it stays 1 with the new data.
  - word_out_L is stable while word_valid_L=1 and not accepted.
  - word_ready may be asserted independently of word_valid; it has no effect when word_valid=0.
- Lane independence: an interleaved sel sequence builds each lane's word independently. Partial words persist across cycles where other lanes are selected.
- Overflow:
  - Sticky until clear_ovf=1, which zeros all bits next cycle.
  - If clear_ovf and a new overflow event coincide on a lane, set wins (the flag ends at 1).
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package demux_pkg holds:
  - NUM_LANES=4, SEL_W=2;
  - the function lane_slice(n) returning the bit offset n*WIDTH.
- Sub-module lane_deser, instantiated 4x:
  - holds the shift register, counter, holding register, valid and overflow for one lane;
  - inputs: bit_en (bit_valid & sel==n), bit_in, ready, clear_ovf.
- The top level does only sel decode and data_out selection.

Test Plan:
- Reset check: rst=1 for 2 cycles with random inputs -> word_valid=0000, overflow=0000, word_out=0.
- Single lane, WIDTH=8:
  - Stimulus: sel=2, bit_valid=1, bits 1,0,1,0,0,1,1,0; word_ready=0.
  - Response: one cycle after the 8th bit, word_valid=0100 and lane 2 word=8'hA6.
  - Then word_ready[2]=1 for 1 cycle -> word_valid=0000.
- Interleave:
  - Stimulus: alternate sel=0/sel=1 each cycle, lane0 bits all 1, lane1 bits all 0, 16 cycles.
  - Response: word_valid=0011, lane0=8'hFF, lane1=8'h00.
  - Inject bit_valid=0 gaps mid-stream -> same result.
- Overflow:
  - Stimulus: lane 3 completes 8'h5A with word_ready=0, then completes 8'h3C.
  - Response: overflow=1000, lane 3 word stays 8'h5A.
  - clear_ovf=1 -> overflow=0000 next cycle.
- Simultaneous accept and reload: lane 1 holds 8'h11; its 8th bit of 8'h22 arrives with word_ready[1]=1 -> word_valid[1] stays 1, word=8'h22, overflow[1]=0.
- Reset mid-word: lane 0 receives 5 bits, rst pulses, then 8 bits of 8'hC3 -> word=8'hC3 (no residue from the first 5 bits).
